// File: rtl/mult_operand_sequencer.sv
// mult_operand_sequencer: feeds one operand pair at a time into top_multiplier.
// It pulses EA with A, then EB with B, waits MULT_LAT cycles, and captures P_out.
// Latency: 2+MULT_LAT edges from accept to res_valid. Back-to-back throughput is one result per 4+MULT_LAT cycles.
// Backpressure: in_ready is high only in IDLE. res_valid/res_data hold while res_ready is low.
//
// Ports:
//   clk, Reset (async, active-low)
//   in_valid/in_ready/in_a/in_b   operand pair handshake
//   Data_in_A/EA, Data_in_B/EB    multiplier load interface; EA/EB are 1-cycle pulses
//   P_out                         product returned by the multiplier
//   res_valid/res_ready/res_data  result handshake
//   op_count                      completed-result counter
//
// Build option: define MSEQ_OP_COUNT_EN to count result handshakes on op_count.
// When it is undefined, op_count is tied to zero.
// Parameters: N = operand width. MULT_LAT = multiplier latency in cycles, legal range 1..15.

module mult_operand_sequencer #(
  parameter int N        = 8,
  parameter int MULT_LAT = 2
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic [N-1:0]     Data_in_A,
  output logic [N-1:0]     Data_in_B,
  output logic             EA,
  output logic             EB,
  input  logic [2*N-1:0]   P_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*N-1:0]   res_data,
  output logic [15:0]      op_count
);

  // The wait counter runs from MULT_LAT-1 down to 0, so WAIT spans MULT_LAT cycles.
  localparam logic [3:0] WAIT_INIT = 4'(MULT_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     a_q, a_d;      // drives Data_in_A directly
  logic [N-1:0]     b_q, b_d;      // B held until LOAD_B
  logic [N-1:0]     db_q, db_d;    // drives Data_in_B
  logic [3:0]       cnt_q, cnt_d;
  logic [2*N-1:0]   res_q, res_d;

  // Reset is folded in so in_ready stays low while reset is asserted.
  assign in_ready  = (state_q == S_IDLE) && Reset;
  assign EA        = (state_q == S_LOAD_A);
  assign EB        = (state_q == S_LOAD_B);
  assign res_valid = (state_q == S_DONE);
  assign Data_in_A = a_q;
  assign Data_in_B = db_q;
  assign res_data  = res_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        // A is loaded straight into the Data_in_A register. It is first
        // presented in LOAD_A, which is the cycle where EA qualifies it.
        if (in_valid && in_ready) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = S_LOAD_A;
        end
      end
      S_LOAD_A: begin
        // Data_in_B changes only on entry to LOAD_B.
        // Until then it keeps its previous value.
        db_d    = b_q;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        cnt_d   = WAIT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          res_d   = P_out;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

`ifdef MSEQ_OP_COUNT_EN
  logic [15:0] op_cnt_q, op_cnt_d;

  // The counter wraps naturally from 0xFFFF to 0x0000.
  always_comb begin
    op_cnt_d = op_cnt_q;
    if (res_valid && res_ready) op_cnt_d = op_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) op_cnt_q <= '0;
    else        op_cnt_q <= op_cnt_d;
  end

  assign op_count = op_cnt_q;
`else
  assign op_count = 16'h0000;
`endif

endmodule
